systolic_feeder_2x2: RTL and testbench
======================================

// Module: systolic_feeder_2x2
// PURPOSE
//  Host-side driver for the 2x2 output-stationary systolic multiplier (C = A x B).
//  - Accepts full A and B matrices over a valid/ready handshake.
//  - Clears the array, then streams row-skewed A and column-skewed B into its four edge ports.
//  - Waits for the array to drain, captures the four C outputs and returns them over a valid/ready handshake.
// PARAMETERS
//  DATA_W     32  operand/result width; must match the array datapath width
//  DRAIN_CYC  2   zero-feed cycles after the last feed beat before capture; minimum 2
// PORTS
//  clk        in   1         clock; all logic on posedge
//  rst        in   1         synchronous, active-low reset
//  in_valid   in   1         A/B matrix pair valid
//  in_ready   out  1         feeder idle, can accept a pair
//  a_mat      in   4*DATA_W  {A11,A10,A01,A00}; A00 in [DATA_W-1:0]
//  b_mat      in   4*DATA_W  {B11,B10,B01,B00}; same packing
//  arr_clr    out  1         active-high clear, to the array reset input
//  arr_a0     out  DATA_W    A row-0 edge port (array a00)
//  arr_a1     out  DATA_W    A row-1 edge port (array a01)
//  arr_b0     out  DATA_W    B col-0 edge port (array b00)
//  arr_b1     out  DATA_W    B col-1 edge port (array b01)
//  arr_c00    in   DATA_W    array result C00 (arr_c01, arr_c10, arr_c11 have the same width and role)
//  out_valid  out  1         c_mat holds a completed result
//  out_ready  in   1         consumer accepts c_mat
//  c_mat      out  4*DATA_W  {C11,C10,C01,C00}; same packing as a_mat
// BEHAVIOUR
//  Reset (rst=0 at posedge), regardless of state:
//  - state=IDLE
//  - in_ready=1, arr_clr=1, out_valid=0
//  - arr_a0/arr_a1/arr_b0/arr_b1=0, c_mat=0
//  Registers:
//  - All outputs are registered.
//  - A/B are latched into internal registers on the in_valid&&in_ready edge.
//  FSM: IDLE -> CLEAR -> FEED -> DRAIN -> RESULT -> IDLE
//  - IDLE: in_ready=1, arr_clr=0, edge ports=0. On in_valid: latch A/B, go to CLEAR.
//  - CLEAR: exactly 1 cycle with arr_clr=1 and edge ports=0. Go to FEED with beat=0.
//  - FEED: beat counter 0..2, arr_clr=0. Port values per beat (outside these beats, ports=0):
//      beat0: a0=A00, b0=B00, a1=0,   b1=0
//      beat1: a0=A01, b0=B10, a1=A10, b1=B01
//      beat2: a0=0,   b0=0,   a1=A11, b1=B11
//    After beat2, go to DRAIN.
//  - DRAIN: DRAIN_CYC cycles with all ports=0. On the edge ending the last DRAIN cycle:
//    c_mat<={arr_c11,arr_c10,arr_c01,arr_c00}, out_valid<=1, go to RESULT.
//  - RESULT: hold c_mat and out_valid=1 until out_ready=1. On that edge: out_valid<=0, go to IDLE.
//  Handshake and latency:
//  - in_ready=1 only in IDLE.
//  - in_valid outside IDLE is ignored; the producer must hold its data.
//  - Latency: out_valid rises 1+3+DRAIN_CYC+1 = 7 cycles (default) after the accepting edge.
//  - Throughput: one pair per 7+1 cycles when out_ready is held high.
//  Arithmetic:
//  - The feeder does no arithmetic.
//  - Results are whatever the array produced: products and sums wrap mod 2^DATA_W.
//  Boundaries:
//  - out_ready low: hold in RESULT indefinitely; c_mat is stable and edge ports stay 0.
//  - out_ready high on the same cycle out_valid rises: handshake completes on the next edge (1-cycle minimum valid).
//  - in_valid during RESULT: not accepted until the cycle after returning to IDLE.
//  - Reset mid-FEED or mid-DRAIN: abort, apply reset values, discard the partial result.
//    The next job's CLEAR wipes array state.
//  - Back-to-back jobs: CLEAR guarantees no accumulation carries over from the previous job.
// TESTING (bench = this block + 2x2 systolic array)
//  1. A=[[1,2],[3,4]], B=[[5,6],[7,8]]
//     -> C00=19, C01=22, C10=43, C11=50; out_valid 7 cycles after accept.
//  2. A=[[9,8],[7,6]], B=I
//     -> C=[[9,8],[7,6]]; check arr_* beat pattern exactly, including zero beats.
//  3. Job 1, then job 2 back-to-back (A=I, B=[[2,0],[0,2]])
//     -> second C=[[2,0],[0,2]]; no residue from job 1.
//  4. out_ready=0 for 20 cycles in RESULT
//     -> c_mat stable, in_ready=0, in_valid ignored; accept occurs after release.
//  5. rst=0 during FEED beat1
//     -> next cycle all outputs at reset values; a new job (test 1 data) still yields 19/22/43/50.
//  6. A00=32'h8000_0000, B00=2, others 0
//     -> C00=0 (wrap); A=all 32'hFFFF_FFFF, B=I -> C=all 32'hFFFF_FFFF.

Source files
------------

// File: rtl/systolic_feeder_2x2.sv
// Host-side feeder for a 2x2 output-stationary systolic multiplier: latches A/B,
// clears the array, streams skewed operands, drains, then returns C over valid/ready.
module systolic_feeder_2x2 #(
  parameter int DATA_W    = 32,
  parameter int DRAIN_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DATA_W-1:0] a_mat,
  input  logic [4*DATA_W-1:0] b_mat,
  output logic                arr_clr,
  output logic [DATA_W-1:0]   arr_a0,
  output logic [DATA_W-1:0]   arr_a1,
  output logic [DATA_W-1:0]   arr_b0,
  output logic [DATA_W-1:0]   arr_b1,
  input  logic [DATA_W-1:0]   arr_c00,
  input  logic [DATA_W-1:0]   arr_c01,
  input  logic [DATA_W-1:0]   arr_c10,
  input  logic [DATA_W-1:0]   arr_c11,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DATA_W-1:0] c_mat
);

  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, RESULT} state_t;

  state_t                   state, ns;
  logic [1:0]               beat, beat_n;
  logic [DCW-1:0]           dcnt, dcnt_n;
  logic [3:0][DATA_W-1:0]   a_q, b_q;
  logic                     acc, cap, ov_n;
  logic [DATA_W-1:0]        a0_n, a1_n, b0_n, b1_n;

  // Outputs are registered from the next state, so they always describe the current state.
  always_comb begin
    ns     = state;
    beat_n = beat;
    dcnt_n = dcnt;
    ov_n   = out_valid;
    acc    = 1'b0;
    cap    = 1'b0;
    case (state)
      IDLE:   if (in_valid) begin acc = 1'b1; ns = CLEAR; end
      CLEAR:  begin ns = FEED; beat_n = '0; end
      FEED:   if (beat == 2'd2) begin ns = DRAIN; dcnt_n = '0; end
              else beat_n = beat + 2'd1;
      DRAIN:  if (dcnt == DCW'(DRAIN_CYC-1)) begin ns = RESULT; cap = 1'b1; ov_n = 1'b1; end
              else dcnt_n = dcnt + 1'b1;
      RESULT: if (out_ready) begin ns = IDLE; ov_n = 1'b0; end
      default: ns = IDLE;
    endcase

    a0_n = '0;
    a1_n = '0;
    b0_n = '0;
    b1_n = '0;
    // Row 1 / column 1 run one beat behind row 0 / column 0 (index: 0=x00 1=x01 2=x10 3=x11).
    if (ns == FEED) begin
      case (beat_n)
        2'd0: begin a0_n = a_q[0]; b0_n = b_q[0]; end
        2'd1: begin a0_n = a_q[1]; b0_n = b_q[2]; a1_n = a_q[2]; b1_n = b_q[1]; end
        default: begin a1_n = a_q[3]; b1_n = b_q[3]; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      beat      <= '0;
      dcnt      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      in_ready  <= 1'b1;
      arr_clr   <= 1'b1;
      out_valid <= 1'b0;
      arr_a0    <= '0;
      arr_a1    <= '0;
      arr_b0    <= '0;
      arr_b1    <= '0;
      c_mat     <= '0;
    end else begin
      state     <= ns;
      beat      <= beat_n;
      dcnt      <= dcnt_n;
      in_ready  <= (ns == IDLE);
      arr_clr   <= (ns == CLEAR);
      out_valid <= ov_n;
      arr_a0    <= a0_n;
      arr_a1    <= a1_n;
      arr_b0    <= b0_n;
      arr_b1    <= b1_n;
      if (acc) begin
        a_q <= a_mat;
        b_q <= b_mat;
      end
      if (cap) c_mat <= {arr_c11, arr_c10, arr_c01, arr_c00};
    end
  end

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Bench: feeder plus a behavioural 2x2 output-stationary array; results checked
// against a plain matrix-multiply model and the skewed beat pattern.
module tb_systolic_feeder_2x2;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [4*W-1:0] a_mat = '0;
  logic [4*W-1:0] b_mat = '0;
  logic           arr_clr;
  logic [W-1:0]   arr_a0, arr_a1, arr_b0, arr_b1;
  logic [W-1:0]   arr_c00, arr_c01, arr_c10, arr_c11;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [4*W-1:0] c_mat;

  int checks = 0;
  int errors = 0;
  logic [4*W-1:0] pend_a = '0;
  logic [4*W-1:0] pend_b = '0;

  always #5 clk = ~clk;

  systolic_feeder_2x2 #(.DATA_W(W), .DRAIN_CYC(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_mat(a_mat), .b_mat(b_mat), .arr_clr(arr_clr),
    .arr_a0(arr_a0), .arr_a1(arr_a1), .arr_b0(arr_b0), .arr_b1(arr_b1),
    .arr_c00(arr_c00), .arr_c01(arr_c01), .arr_c10(arr_c10), .arr_c11(arr_c11),
    .out_valid(out_valid), .out_ready(out_ready), .c_mat(c_mat)
  );

  // Output-stationary array: A flows right, B flows down, each PE accumulates a*b.
  logic [W-1:0] ra00, rb00, ra10, rb01;
  always_ff @(posedge clk) begin
    if (arr_clr) begin
      arr_c00 <= '0; arr_c01 <= '0; arr_c10 <= '0; arr_c11 <= '0;
      ra00 <= '0; rb00 <= '0; ra10 <= '0; rb01 <= '0;
    end else begin
      arr_c00 <= arr_c00 + arr_a0 * arr_b0;
      arr_c01 <= arr_c01 + ra00 * arr_b1;
      arr_c10 <= arr_c10 + arr_a1 * rb00;
      arr_c11 <= arr_c11 + ra10 * rb01;
      ra00 <= arr_a0; rb00 <= arr_b0; ra10 <= arr_a1; rb01 <= arr_b1;
    end
  end

  function automatic logic [4*W-1:0] mm(input logic [4*W-1:0] a, input logic [4*W-1:0] b);
    logic [W-1:0] am [2][2];
    logic [W-1:0] bm [2][2];
    logic [4*W-1:0] r;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        am[i][j] = a[(2*i+j)*W +: W];
        bm[i][j] = b[(2*i+j)*W +: W];
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        r[(2*i+j)*W +: W] = am[i][0] * bm[0][j] + am[i][1] * bm[1][j];
    return r;
  endfunction

  // {clr, a0, a1, b0, b1} expected k cycles after the accepting cycle.
  function automatic logic [4*W:0] exp_ports(input int k, input logic [4*W-1:0] a,
                                             input logic [4*W-1:0] b);
    logic [W-1:0] a0, a1, b0, b1;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    case (k)
      2: begin a0 = a[0*W +: W]; b0 = b[0*W +: W]; end
      3: begin a0 = a[1*W +: W]; b0 = b[2*W +: W]; a1 = a[2*W +: W]; b1 = b[1*W +: W]; end
      4: begin a1 = a[3*W +: W]; b1 = b[3*W +: W]; end
      default: ;
    endcase
    return {(k == 1), a0, a1, b0, b1};
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Caller is at a negedge. Returns at the negedge after the result handshake.
  task automatic run_job(input logic [4*W-1:0] a, input logic [4*W-1:0] b,
                         input int hold, output logic [4*W-1:0] c);
    int n;
    int k;
    c = '0;
    out_ready = (hold == 0);
    a_mat = a; b_mat = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready never rose");
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    a_mat = {$urandom, $urandom, $urandom, $urandom};
    b_mat = {$urandom, $urandom, $urandom, $urandom};
    k = 1;
    while (!out_valid && k < 30) begin
      chk($sformatf("ports_k%0d", k), {arr_clr, arr_a0, arr_a1, arr_b0, arr_b1}, exp_ports(k, a, b));
      @(negedge clk);
      k++;
    end
    chk("latency", k, 7);
    chk("result_ports", {arr_clr, arr_a0, arr_a1, arr_b0, arr_b1}, '0);
    c = c_mat;
    for (int h = 0; h < hold; h++) begin
      a_mat = pend_a; b_mat = pend_b; in_valid = 1'b1;
      @(negedge clk);
      chk("hold_c", c_mat, c);
      chk("hold_ctl", {out_valid, in_ready}, 2'b10);
      chk("hold_ports", {arr_clr, arr_a0, arr_a1, arr_b0, arr_b1}, '0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_ctl", {out_valid, in_ready}, 2'b01);
  endtask

  typedef struct {
    logic [4*W-1:0] a;
    logic [4*W-1:0] b;
    logic [4*W-1:0] c;
  } vec_t;

  vec_t tbl [7];
  logic [4*W-1:0] c;
  logic [4*W-1:0] ra [25];
  logic [4*W-1:0] rb [25];

  initial begin
    tbl[0] = '{ {32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5},
                {32'd50, 32'd43, 32'd22, 32'd19} };
    tbl[1] = '{ {32'd1, 32'd0, 32'd0, 32'd1}, {32'd2, 32'd0, 32'd0, 32'd2},
                {32'd2, 32'd0, 32'd0, 32'd2} };
    tbl[2] = '{ {32'd6, 32'd7, 32'd8, 32'd9}, {32'd1, 32'd0, 32'd0, 32'd1},
                {32'd6, 32'd7, 32'd8, 32'd9} };
    tbl[3] = '{ {32'd0, 32'd0, 32'd0, 32'h8000_0000}, {32'd0, 32'd0, 32'd0, 32'd2},
                {32'd0, 32'd0, 32'd0, 32'd0} };
    tbl[4] = '{ {4{32'hFFFF_FFFF}}, {32'd1, 32'd0, 32'd0, 32'd1}, {4{32'hFFFF_FFFF}} };
    tbl[5] = '{ {4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}}, {32'd2, 32'd2, 32'd2, 32'd2} };
    tbl[6] = '{ {32'd0, 32'd1, 32'd1, 32'd0}, {32'd4, 32'd3, 32'd2, 32'd1},
                {32'd2, 32'd1, 32'd4, 32'd3} };

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {in_ready, arr_clr, out_valid}, 3'b110);
    chk("rst_ports", {arr_a0, arr_a1, arr_b0, arr_b1}, '0);
    chk("rst_c", c_mat, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ctl", {in_ready, arr_clr, out_valid}, 3'b100);

    // Table jobs run back-to-back; job 1 then the identity job exposes any residue.
    for (int i = 0; i < 7; i++) begin
      run_job(tbl[i].a, tbl[i].b, 0, c);
      chk($sformatf("tbl%0d_c", i), c, tbl[i].c);
    end

    // Consumer stalls 20 cycles while a new pair waits on in_valid.
    pend_a = tbl[0].a; pend_b = tbl[0].b;
    run_job(tbl[2].a, tbl[2].b, 20, c);
    chk("stall_c", c, tbl[2].c);
    run_job(tbl[0].a, tbl[0].b, 0, c);
    chk("after_stall_c", c, tbl[0].c);

    // Reset during FEED beat1, then a fresh job.
    a_mat = tbl[0].a; b_mat = tbl[0].b; in_valid = 1'b1;
    begin
      int n;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
    end
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_feed_a0", arr_a0, 32'd2);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ctl", {in_ready, arr_clr, out_valid}, 3'b110);
    chk("midrst_ports", {arr_a0, arr_a1, arr_b0, arr_b1}, '0);
    chk("midrst_c", c_mat, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_idle", {in_ready, arr_clr, out_valid}, 3'b100);
    run_job(tbl[0].a, tbl[0].b, 0, c);
    chk("post_rst_c", c, tbl[0].c);

    // Random jobs with random consumer stalls.
    for (int i = 0; i < 25; i++) begin
      for (int e = 0; e < 4; e++) begin
        logic [W-1:0] x, y;
        x = $urandom; y = $urandom;
        if ($urandom_range(0, 1) == 1) x = x & 32'hF;
        if ($urandom_range(0, 1) == 1) y = y & 32'hF;
        ra[i][e*W +: W] = x;
        rb[i][e*W +: W] = y;
      end
    end
    for (int i = 0; i < 24; i++) begin
      pend_a = ra[i+1]; pend_b = rb[i+1];
      run_job(ra[i], rb[i], (i == 23) ? 0 : int'($urandom_range(0, 3)), c);
      chk($sformatf("rand%0d_c", i), c, mm(ra[i], rb[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
